// File: rtl/video_timing_decoder.sv
// rtl/video_timing_decoder.sv - recovers pixel coordinates, raster geometry and lock from a sync/DE video stream
module video_timing_decoder #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       hs,
    input  logic       vs,
    input  logic       de,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       new_frame,
    output logic [9:0] h_total,
    output logic [9:0] v_total,
    output logic [9:0] active_w,
    output logic [9:0] active_h,
    output logic       locked
);

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    logic        hs_d, vs_d, de_d;
    logic [9:0]  hcnt, vlines, xcnt, actline;
    logic [3:0]  stable_cnt;
    logic        mismatch;

    logic        hs_rise, vs_rise, de_rise, de_fall;
    logic [10:0] line_len;
    logic        line_mis, hcnt_sat, frame_stable;
    logic [9:0]  vlines_inc, actline_inc, x_idx;
    logic [3:0]  stable_inc;

    always_comb begin
        hs_rise      = hs & ~hs_d;
        vs_rise      = vs & ~vs_d;
        de_rise      = de & ~de_d;
        de_fall      = ~de & de_d;
        // hcnt tops out at 1023, so a line length of 1024 means "no HS seen"
        line_len     = {1'b0, hcnt} + 11'd1;
        line_mis     = hs_rise && (h_total != 10'd0) && (line_len != {1'b0, h_total});
        hcnt_sat     = !hs_rise && (hcnt >= CNT_MAX - 10'd1);
        vlines_inc   = (hs_rise && vlines != CNT_MAX) ? vlines + 10'd1 : vlines;
        actline_inc  = de_fall ? actline + 10'd1 : actline;
        x_idx        = de_rise ? 10'd0 : xcnt;
        frame_stable = (v_total != 10'd0) && (vlines_inc == v_total) && !(mismatch || line_mis);
        stable_inc   = (stable_cnt == LOCK_N) ? stable_cnt : stable_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            de_d       <= 1'b0;
            hcnt       <= '0;
            vlines     <= '0;
            xcnt       <= '0;
            actline    <= '0;
            stable_cnt <= '0;
            mismatch   <= 1'b0;
            pix_valid  <= 1'b0;
            x          <= '0;
            y          <= '0;
            new_frame  <= 1'b0;
            h_total    <= '0;
            v_total    <= '0;
            active_w   <= '0;
            active_h   <= '0;
            locked     <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            new_frame <= 1'b0;
            if (ce_pix) begin
                hs_d      <= hs;
                vs_d      <= vs;
                de_d      <= de;
                pix_valid <= de;
                new_frame <= vs_rise;

                if (hs_rise) begin
                    hcnt    <= '0;
                    h_total <= line_len[10] ? CNT_MAX : line_len[9:0];
                end else if (hcnt != CNT_MAX) begin
                    hcnt <= hcnt + 10'd1;
                end
                vlines <= vlines_inc;
                if (line_mis) begin
                    mismatch <= 1'b1;
                    locked   <= 1'b0;
                end

                if (de) begin
                    x    <= x_idx;
                    y    <= actline;
                    xcnt <= x_idx + 10'd1;
                end
                if (de_fall)
                    active_w <= xcnt;
                actline <= actline_inc;

                // frame close: a same-tick HS rise and DE fall already belong to this frame
                if (vs_rise) begin
                    v_total  <= vlines_inc;
                    vlines   <= '0;
                    active_h <= actline_inc;
                    actline  <= '0;
                    xcnt     <= '0;
                    mismatch <= 1'b0;
                    if (frame_stable) begin
                        stable_cnt <= stable_inc;
                        if (stable_inc == LOCK_N)
                            locked <= 1'b1;
                    end else begin
                        stable_cnt <= '0;
                        locked     <= 1'b0;
                    end
                end

                if (hcnt_sat) begin
                    locked     <= 1'b0;
                    stable_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_decoder.sv
// tb/tb_video_timing_decoder.sv - randomized raster stimulus checked against a tick-level behavioural model
module tb_video_timing_decoder;

    localparam int LF = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic       de = 1'b0;
    logic       pix_valid, new_frame, locked;
    logic [9:0] x, y, h_total, v_total, active_w, active_h;

    video_timing_decoder #(.LOCK_FRAMES(LF)) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
        .pix_valid(pix_valid), .x(x), .y(y), .new_frame(new_frame),
        .h_total(h_total), .v_total(v_total), .active_w(active_w), .active_h(active_h),
        .locked(locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // raster generator
    int H, V, hs0, hs1, vs0, vs1, dh0, dh1, dv0, dv1;
    int gh, gv, cur_len, kill;
    bit perturb_req, short_done;

    // reference model state, expressed as stream observations
    int m_t, m_last_hs, m_lines, m_run, m_actl, m_stable, m_vs_cnt, m_hr_cnt;
    bit m_mis, m_phs, m_pvs, m_pde;
    int e_x, e_y, e_ht, e_vt, e_aw, e_ah;
    bit e_pv, e_nf, e_lk;

    task automatic model_reset();
        m_t = 0; m_last_hs = 0; m_lines = 0; m_run = 0; m_actl = 0; m_stable = 0;
        m_mis = 0; m_phs = 0; m_pvs = 0; m_pde = 0;
        e_x = 0; e_y = 0; e_ht = 0; e_vt = 0; e_aw = 0; e_ah = 0;
        e_pv = 0; e_nf = 0; e_lk = 0;
    endtask

    task automatic model_clk(input bit ce, input bit h, input bit v, input bit d);
        bit hr, vr, dr, df, ok;
        int len, lenc;
        e_pv = 0;
        e_nf = 0;
        if (!ce) return;
        m_t++;
        hr = h && !m_phs; vr = v && !m_pvs; dr = d && !m_pde; df = !d && m_pde;
        m_phs = h; m_pvs = v; m_pde = d;
        e_pv = d;
        e_nf = vr;
        if (d) begin
            if (dr) m_run = 0;
            e_x = m_run;
            e_y = m_actl;
            m_run++;
        end
        if (df) begin
            e_aw = m_run;
            m_actl++;
        end
        if (hr) begin
            m_hr_cnt++;
            len = m_t - m_last_hs;
            m_last_hs = m_t;
            lenc = (len > 1024) ? 1024 : len;
            if (e_ht != 0 && lenc != e_ht) begin
                m_mis = 1;
                e_lk = 0;
            end
            e_ht = (len > 1023) ? 1023 : len;
            if (m_lines < 1023) m_lines++;
        end
        if (vr) begin
            m_vs_cnt++;
            ok = (e_vt != 0) && (m_lines == e_vt) && !m_mis;
            e_vt = m_lines;
            e_ah = m_actl;
            m_lines = 0; m_actl = 0; m_run = 0; m_mis = 0;
            if (ok) begin
                if (m_stable < LF) m_stable++;
                if (m_stable == LF) e_lk = 1;
            end else begin
                m_stable = 0;
                e_lk = 0;
            end
        end
        if (!hr && (m_t - m_last_hs) >= 1023) begin
            e_lk = 0;
            m_stable = 0;
        end
    endtask

    task automatic compare_all();
        chk("pix_valid", 32'(pix_valid), 32'(e_pv));
        chk("new_frame", 32'(new_frame), 32'(e_nf));
        chk("x", 32'(x), e_x);
        chk("y", 32'(y), e_y);
        chk("h_total", 32'(h_total), e_ht);
        chk("v_total", 32'(v_total), e_vt);
        chk("active_w", 32'(active_w), e_aw);
        chk("active_h", 32'(active_h), e_ah);
        chk("locked", 32'(locked), 32'(e_lk));
    endtask

    task automatic step(input bit ce);
        bit h, v, d;
        h = (gh >= hs0) && (gh <= hs1) && (kill == 0);
        v = (gv >= vs0) && (gv <= vs1);
        d = (gh >= dh0) && (gh <= dh1) && (gv >= dv0) && (gv <= dv1);
        ce_pix = ce; hs = h; vs = v; de = d;
        @(posedge clk);
        #1;
        model_clk(ce, h, v, d);
        compare_all();
        if (ce) begin
            if (kill > 0) kill--;
            gh++;
            if (gh >= cur_len) begin
                if (cur_len != H) short_done = 1;
                gh = 0;
                gv = (gv + 1) % V;
                cur_len = perturb_req ? H - 1 : H;
                perturb_req = 0;
            end
        end
    endtask

    task automatic tick_rand();
        if ($urandom_range(0, 3) == 0) step(1'b0);
        step(1'b1);
    endtask

    task automatic run_until_vs(input int k, input string tag);
        int target, budget;
        target = m_vs_cnt + k;
        budget = 20000;
        while (m_vs_cnt < target && budget > 0) begin
            tick_rand();
            budget--;
        end
        if (m_vs_cnt < target) chk({tag, "_vs_timeout"}, m_vs_cnt, target);
    endtask

    task automatic run_until_hr(input int k, input string tag);
        int target, budget;
        target = m_hr_cnt + k;
        budget = 5000;
        while (m_hr_cnt < target && budget > 0) begin
            tick_rand();
            budget--;
        end
        if (m_hr_cnt < target) chk({tag, "_hs_timeout"}, m_hr_cnt, target);
    endtask

    task automatic run_until_pos(input int px, input int py, input string tag);
        int budget;
        budget = 20000;
        while (!(gh == px && gv == py) && budget > 0) begin
            tick_rand();
            budget--;
        end
        if (budget == 0) chk({tag, "_pos_timeout"}, gv, py);
    endtask

    initial begin
        H = $urandom_range(36, 48);
        V = $urandom_range(18, 24);
        hs0 = H - 8; hs1 = H - 5;
        vs0 = V - 4; vs1 = V - 3;
        dh0 = 0; dh1 = H - 11;
        dv0 = 0; dv1 = V - 7;
        gv = V / 2; gh = $urandom_range(0, H - 1);
        cur_len = H; kill = 0; perturb_req = 0; short_done = 0;
        m_vs_cnt = 0; m_hr_cnt = 0;
        model_reset();

        // reset state, released mid-frame
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;

        run_until_vs(2, "lock_seq");
        chk("geom_h_total", 32'(h_total), H);
        chk("geom_v_total", 32'(v_total), V);
        chk("geom_active_w", 32'(active_w), dh1 - dh0 + 1);
        chk("geom_active_h", 32'(active_h), dv1 - dv0 + 1);
        run_until_vs(1, "lock_seq");
        chk("unlocked_vs3", 32'(locked), 0);
        run_until_vs(1, "lock_seq");
        chk("locked_vs4", 32'(locked), 1);

        // overscan window, changed during vertical blanking
        dh0 = 2; dh1 = H - 13; dv0 = 1; dv1 = V - 8;
        run_until_vs(2, "overscan");
        chk("os_active_w", 32'(active_w), dh1 - dh0 + 1);
        chk("os_active_h", 32'(active_h), dv1 - dv0 + 1);
        chk("os_locked", 32'(locked), 1);

        // pixel-enable gap mid-line inside the active window
        run_until_pos(dh0 + 3, dv0 + 1, "gap");
        repeat (10) step(1'b0);
        repeat (20) tick_rand();

        // one short line while locked
        run_until_vs(1, "perturb");
        chk("pre_perturb_locked", 32'(locked), 1);
        perturb_req = 1;
        short_done = 0;
        while (!short_done) tick_rand();
        run_until_hr(1, "perturb");
        chk("perturb_h_total", 32'(h_total), H - 1);
        chk("perturb_locked", 32'(locked), 0);
        run_until_vs(2, "relock");
        chk("relock_pending", 32'(locked), 0);
        run_until_vs(1, "relock");
        chk("relock_done", 32'(locked), 1);

        // HS removed for 1100 ticks
        kill = 1100;
        while (kill > 0) tick_rand();
        chk("hs_loss_locked", 32'(locked), 0);
        chk("hs_loss_h_total", 32'(h_total), H);
        run_until_vs(5, "hs_recover");
        chk("hs_recover_locked", 32'(locked), 1);

        // asynchronous reset mid-line while locked
        run_until_pos(H / 2, 2, "areset");
        chk("pre_reset_locked", 32'(locked), 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
        run_until_vs(3, "post_reset");
        chk("post_reset_vs3", 32'(locked), 0);
        run_until_vs(1, "post_reset");
        chk("post_reset_vs4", 32'(locked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
